// File: rtl/dc_useq.sv
// dc_useq: microsequencer for the F11 control chip.
// Registers the microaddress feeding the microcode ROM. The next address comes from
// the ROM next-address field, the PLA translation, a circular return stack, or a
// fixed trap/interrupt/reset vector. Bus-reply waits are bounded by a timeout.
module dc_useq #(
  parameter int unsigned STK_D   = 4,
  parameter int unsigned TMO_W   = 6,
  parameter int unsigned TMO_LIM = 48,
  parameter logic [8:0]  RST_VEC = 9'h1FF,
  parameter logic [8:0]  TRP_VEC = 9'h1FE,
  parameter logic [8:0]  IRQ_VEC = 9'h1FD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic [8:0]  rom_na,
  input  logic [2:0]  rom_op,
  input  logic        bus_rply,
  input  logic        irq,
  input  logic [8:0]  pla_ma,
  input  logic [15:0] pla_mc,
  output logic [6:0]  pla_a,
  output logic [15:0] pla_d,
  output logic [8:0]  ua,
  output logic [15:0] mc,
  output logic        mc_pla,
  output logic        bus_tmo,
  output logic        stk_ovf,
  output logic        stk_unf
);

  localparam int unsigned PW = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam int unsigned CW = $clog2(STK_D + 1);

  localparam logic [2:0] OP_CALL  = 3'd1;
  localparam logic [2:0] OP_RET   = 3'd2;
  localparam logic [2:0] OP_WAIT  = 3'd3;
  localparam logic [2:0] OP_FETCH = 3'd4;

  localparam logic [PW-1:0]    PTR_LAST = PW'(STK_D - 1);
  localparam logic [CW-1:0]    DEPTH_FULL = CW'(STK_D);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIM - 1);

  logic [8:0]       ua_q, ua_d;
  logic [15:0]      mc_q, mc_d;
  logic             mc_pla_q, mc_pla_d;
  logic             bus_tmo_q, bus_tmo_d;
  logic             stk_ovf_q, stk_ovf_d;
  logic             stk_unf_q, stk_unf_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [PW-1:0]    sp_q, sp_d;          // next slot to write; top of stack is sp_q-1
  logic [CW-1:0]    depth_q, depth_d;
  logic [8:0]       mem_q [STK_D];
  logic [8:0]       mem_d [STK_D];

  logic             tgt_pla;
  logic [8:0]       tgt_ua;
  logic             take_tgt;
  logic [PW-1:0]    sp_inc, sp_dec;

  // PLA is driven straight from the ROM word and IR; its answer settles this cycle.
  assign pla_a = rom_na[6:0];
  assign pla_d = ir;

  // Target resolution and circular stack pointer arithmetic.
  always_comb begin
    tgt_pla = (rom_na[8:7] == 2'b00);
    tgt_ua  = tgt_pla ? pla_ma : rom_na;
    sp_inc  = (sp_q == PTR_LAST) ? '0 : sp_q + PW'(1);
    sp_dec  = (sp_q == '0) ? PTR_LAST : sp_q - PW'(1);
  end

  // Next-state decode of the current ROM sequencer op.
  always_comb begin
    ua_d      = ua_q;
    mc_d      = mc_q;
    mc_pla_d  = 1'b0;
    bus_tmo_d = 1'b0;
    stk_ovf_d = stk_ovf_q;
    stk_unf_d = stk_unf_q;
    tmo_cnt_d = '0;
    sp_d      = sp_q;
    depth_d   = depth_q;
    mem_d     = mem_q;
    take_tgt  = 1'b0;

    case (rom_op)
      OP_CALL: begin
        // A push on a full stack lands on the oldest slot, so depth saturates.
        mem_d[sp_q] = ua_q + 9'd1;
        sp_d        = sp_inc;
        if (depth_q == DEPTH_FULL) stk_ovf_d = 1'b1;
        else                       depth_d   = depth_q + CW'(1);
        take_tgt    = 1'b1;
      end
      OP_RET: begin
        if (depth_q != '0) begin
          ua_d    = mem_q[sp_dec];
          sp_d    = sp_dec;
          depth_d = depth_q - CW'(1);
        end else begin
          ua_d      = TRP_VEC;
          stk_unf_d = 1'b1;
        end
      end
      OP_WAIT: begin
        // A reply on the limit cycle still wins over the trap.
        if (bus_rply) begin
          take_tgt = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          ua_d      = TRP_VEC;
          bus_tmo_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      OP_FETCH: begin
        if (irq) ua_d = IRQ_VEC;
        else     take_tgt = 1'b1;
      end
      default: take_tgt = 1'b1;
    endcase

    if (take_tgt) begin
      ua_d = tgt_ua;
      if (tgt_pla) begin
        mc_d     = pla_mc;
        mc_pla_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ua_q      <= RST_VEC;
      mc_q      <= '0;
      mc_pla_q  <= 1'b0;
      bus_tmo_q <= 1'b0;
      stk_ovf_q <= 1'b0;
      stk_unf_q <= 1'b0;
      tmo_cnt_q <= '0;
      sp_q      <= '0;
      depth_q   <= '0;
      mem_q     <= '{default: '0};
    end else begin
      ua_q      <= ua_d;
      mc_q      <= mc_d;
      mc_pla_q  <= mc_pla_d;
      bus_tmo_q <= bus_tmo_d;
      stk_ovf_q <= stk_ovf_d;
      stk_unf_q <= stk_unf_d;
      tmo_cnt_q <= tmo_cnt_d;
      sp_q      <= sp_d;
      depth_q   <= depth_d;
      mem_q     <= mem_d;
    end
  end

  assign ua      = ua_q;
  assign mc      = mc_q;
  assign mc_pla  = mc_pla_q;
  assign bus_tmo = bus_tmo_q;
  assign stk_ovf = stk_ovf_q;
  assign stk_unf = stk_unf_q;

endmodule

// File: tb/tb_dc_useq.sv
// Scoreboard bench for dc_useq: the stimulus process drives one ROM word per cycle and
// pushes the reference model's expected outputs; the monitor pops and compares them.
module tb_dc_useq;

  localparam int         STK_D   = 4;
  localparam int         TMO_LIM = 48;
  localparam logic [8:0] RST_VEC = 9'h1FF;
  localparam logic [8:0] TRP_VEC = 9'h1FE;
  localparam logic [8:0] IRQ_VEC = 9'h1FD;

  localparam logic [2:0] SEQ = 3'd0, CALL = 3'd1, RET = 3'd2, WAIT = 3'd3, FETCH = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic [8:0]  rom_na = '0;
  logic [2:0]  rom_op = '0;
  logic        bus_rply = 1'b0;
  logic        irq = 1'b0;
  logic [8:0]  pla_ma = '0;
  logic [15:0] pla_mc = '0;
  logic [6:0]  pla_a;
  logic [15:0] pla_d;
  logic [8:0]  ua;
  logic [15:0] mc;
  logic        mc_pla, bus_tmo, stk_ovf, stk_unf;

  always #5 clk = ~clk;

  dc_useq #(
    .STK_D(STK_D), .TMO_W(6), .TMO_LIM(TMO_LIM),
    .RST_VEC(RST_VEC), .TRP_VEC(TRP_VEC), .IRQ_VEC(IRQ_VEC)
  ) dut (
    .clk(clk), .rst(rst), .ir(ir), .rom_na(rom_na), .rom_op(rom_op),
    .bus_rply(bus_rply), .irq(irq), .pla_ma(pla_ma), .pla_mc(pla_mc),
    .pla_a(pla_a), .pla_d(pla_d), .ua(ua), .mc(mc), .mc_pla(mc_pla),
    .bus_tmo(bus_tmo), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  typedef struct {
    logic [8:0]  ua;
    logic [15:0] mc;
    logic        mc_pla, tmo, ovf, unf;
    logic [6:0]  pla_a;
    logic [15:0] pla_d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: return stack as a queue (newest at back), wait as a silent-cycle tally.
  logic [8:0]  m_ua = RST_VEC;
  logic [15:0] m_mc = '0;
  logic        m_pla = 1'b0, m_tmo = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  logic [8:0]  m_stk[$];
  int          m_silent = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic m_target(input logic [8:0] x);
    if (x[8:7] == 2'b00) begin
      m_ua  = pla_ma;
      m_mc  = pla_mc;
      m_pla = 1'b1;
    end else begin
      m_ua = x;
    end
  endtask

  task automatic model_step();
    exp_t e;
    if (rst) begin
      m_ua = RST_VEC; m_mc = '0; m_pla = 0; m_tmo = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
      m_silent = 0;
    end else begin
      m_pla = 1'b0;
      m_tmo = 1'b0;
      if (rom_op != WAIT) m_silent = 0;
      case (rom_op)
        CALL: begin
          if (m_stk.size() == STK_D) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_stk.push_back(m_ua + 9'd1);
          m_target(rom_na);
        end
        RET: begin
          if (m_stk.size() > 0) m_ua = m_stk.pop_back();
          else begin m_ua = TRP_VEC; m_unf = 1'b1; end
        end
        WAIT: begin
          if (bus_rply) begin
            m_target(rom_na);
            m_silent = 0;
          end else if (m_silent == TMO_LIM - 1) begin
            m_ua = TRP_VEC; m_tmo = 1'b1; m_silent = 0;
          end else begin
            m_silent++;
          end
        end
        FETCH: begin
          if (irq) m_ua = IRQ_VEC;
          else     m_target(rom_na);
        end
        default: m_target(rom_na);
      endcase
    end
    e.ua = m_ua; e.mc = m_mc; e.mc_pla = m_pla; e.tmo = m_tmo;
    e.ovf = m_ovf; e.unf = m_unf; e.pla_a = rom_na[6:0]; e.pla_d = ir;
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [2:0] op, input logic [8:0] na,
                       input logic rp, input logic iq, input logic [8:0] pma,
                       input logic [15:0] pmc);
    @(negedge clk);
    rst = r; rom_op = op; rom_na = na; bus_rply = rp; irq = iq;
    pla_ma = pma; pla_mc = pmc; ir = 16'($urandom);
    model_step();
  endtask

  // Monitor: one registered result per clock; inputs are still stable at posedge+1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("ua", 32'(ua), 32'(e.ua));
        cmp("mc", 32'(mc), 32'(e.mc));
        cmp("mc_pla", 32'(mc_pla), 32'(e.mc_pla));
        cmp("bus_tmo", 32'(bus_tmo), 32'(e.tmo));
        cmp("stk_ovf", 32'(stk_ovf), 32'(e.ovf));
        cmp("stk_unf", 32'(stk_unf), 32'(e.unf));
        cmp("pla_a", 32'(pla_a), 32'(e.pla_a));
        cmp("pla_d", 32'(pla_d), 32'(e.pla_d));
      end
    end
  end

  // Stimulus: directed scenarios, then randomized ROM words.
  initial begin
    logic [2:0] op;
    int         r;

    drive(1, SEQ, 9'h000, 0, 0, 9'h000, 16'h0000);
    drive(1, SEQ, 9'h000, 0, 0, 9'h000, 16'h0000);
    drive(0, SEQ, 9'h0A5, 0, 0, 9'h111, 16'h1234);
    drive(0, SEQ, 9'h012, 0, 0, 9'h134, 16'hBEEF);

    // CALL from 0x040 to 0x1A0 then RET back to 0x041
    drive(0, SEQ, 9'h000, 0, 0, 9'h040, 16'h4040);
    drive(0, CALL, 9'h1A0, 0, 0, 9'h0FF, 16'hAAAA);
    drive(0, RET, 9'h055, 0, 0, 9'h0FF, 16'hBBBB);

    // Overflow then underflow on a clean stack
    drive(1, SEQ, 9'h000, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < 5; i++) drive(0, CALL, 9'h180 + 9'(i), 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < 5; i++) drive(0, RET, 9'h180, 0, 0, 9'h000, 16'h0000);

    // Full timeout, then a reply on the last allowed cycle
    for (int i = 0; i < TMO_LIM; i++) drive(0, WAIT, 9'h155, 0, 0, 9'h000, 16'h0000);
    drive(0, SEQ, 9'h1C3, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < TMO_LIM - 1; i++) drive(0, WAIT, 9'h155, 0, 0, 9'h000, 16'h0000);
    drive(0, WAIT, 9'h155, 1, 0, 9'h000, 16'h0000);
    drive(0, SEQ, 9'h03C, 0, 0, 9'h0E1, 16'hCAFE);

    // Interrupt taken at FETCH, ignored elsewhere
    drive(0, FETCH, 9'h1C0, 0, 1, 9'h000, 16'h0000);
    drive(0, SEQ, 9'h1C0, 0, 1, 9'h000, 16'h0000);
    drive(0, FETCH, 9'h0C4, 0, 0, 9'h000, 16'h0000);

    // Reset mid-WAIT must clear the wait count
    for (int i = 0; i < 20; i++) drive(0, WAIT, 9'h155, 0, 0, 9'h000, 16'h0000);
    drive(1, WAIT, 9'h155, 0, 0, 9'h000, 16'h0000);
    for (int i = 0; i < TMO_LIM; i++) drive(0, WAIT, 9'h155, 0, 0, 9'h000, 16'h0000);
    drive(0, SEQ, 9'h100, 0, 0, 9'h000, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 9: op = ($urandom_range(0, 1) == 0) ? SEQ : 3'($urandom_range(5, 7));
        2, 3:    op = CALL;
        4, 5:    op = RET;
        6, 7:    op = WAIT;
        default: op = FETCH;
      endcase
      drive(($urandom_range(0, 99) == 0), op, 9'($urandom), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) == 0), 9'($urandom), 16'($urandom));
    end

    @(posedge clk);
    #2;
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
